// File: rtl/config_int_add_issue_ctrl.sv
// Issue/precision controller in front of the clock-gated configurable integer adder.
// Registers operands, tracks each operation's exactness through the adder's two stages.
module config_int_add_issue_ctrl #(
  parameter int unsigned DATA_PATH_BITWIDTH = 32,
  parameter int unsigned REFRESH_PERIOD     = 8,
  parameter int unsigned CNT_WIDTH          = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
  input  logic                          mode_wr,
  input  logic [1:0]                    mode_req,
  output logic [DATA_PATH_BITWIDTH-1:0] a,
  output logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic                          reg_en,
  output logic                          res_valid,
  output logic                          res_exact,
  output logic [1:0]                    cur_mode,
  output logic                          busy
);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  localparam logic [1:0] ModePrecise  = 2'd0;
  localparam logic [1:0] ModePeriodic = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(REFRESH_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

  state_e                          state_q;
  logic [DATA_PATH_BITWIDTH-1:0]   a_q, b_q;
  logic                            v0_q, e0_q, v1_q, e1_q;
  logic                            res_valid_q, res_exact_q;
  logic [1:0]                      cur_mode_q, pending_q;
  logic [CNT_WIDTH-1:0]            count_q;

  logic accept;
  logic exact_new;
  logic pipe_empty_next;

  assign accept = in_valid & in_ready;

  // Gated and the reserved encoding 3 both leave the low bits un-refreshed.
  always_comb begin
    exact_new = 1'b0;
    case (cur_mode_q)
      ModePrecise:  exact_new = 1'b1;
      ModePeriodic: exact_new = (count_q == CntLast);
      default:      exact_new = 1'b0;
    endcase
  end

  // Pipe flags as they will be after this edge: nothing new enters while draining,
  // so the pipe is empty once the stage-0 operation has moved on.
  assign pipe_empty_next = ~accept & ~v0_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      a_q         <= '0;
      b_q         <= '0;
      v0_q        <= 1'b0;
      e0_q        <= 1'b0;
      v1_q        <= 1'b0;
      e1_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_exact_q <= 1'b0;
      cur_mode_q  <= ModePrecise;
      pending_q   <= ModePrecise;
      count_q     <= '0;
    end else begin
      v0_q        <= accept;
      e0_q        <= accept & exact_new;
      v1_q        <= v0_q;
      e1_q        <= e0_q;
      res_valid_q <= v1_q;
      res_exact_q <= e1_q;

      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
        if (cur_mode_q == ModePeriodic) begin
          count_q <= (count_q == CntLast) ? '0 : count_q + CntOne;
        end
      end

      unique case (state_q)
        StRun: begin
          if (mode_wr) begin
            if (!v0_q && !v1_q && !accept) begin
              cur_mode_q <= mode_req;
              count_q    <= '0;
            end else begin
              pending_q <= mode_req;
              state_q   <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pipe_empty_next) begin
            cur_mode_q <= mode_wr ? mode_req : pending_q;
            count_q    <= '0;
            state_q    <= StRun;
          end else if (mode_wr) begin
            pending_q <= mode_req;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign in_ready  = (state_q == StRun);
  assign a         = a_q;
  assign b         = b_q;
  // Decoded purely from flops so the clock-gate enable cannot glitch.
  assign reg_en    = (v0_q & e0_q) | (v1_q & e1_q);
  assign res_valid = res_valid_q;
  assign res_exact = res_exact_q;
  assign cur_mode  = cur_mode_q;
  assign busy      = v0_q | v1_q | (state_q == StDrain);

endmodule
